// File: rtl/aes_job_arbiter_if.sv
// Requester-side bundle of the AES job arbiter: operand requests in, results out.
// master = requester side, slave = arbiter side.
interface aes_job_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // Handshakes: req_valid[i] is held with stable operands until the one-cycle req_ack[i];
  // rsp_valid[i] is held with stable rsp_data/rsp_err until the cycle rsp_ready[i] is seen high.
  logic [NUM_REQ-1:0]     req_valid;
  logic [128*NUM_REQ-1:0] req_key;
  logic [128*NUM_REQ-1:0] req_msg;
  logic [NUM_REQ-1:0]     req_ack;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [127:0]           rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_key, req_msg, rsp_ready,
    input  req_ack, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_msg, rsp_ready,
    output req_ack, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// Shares one AES decryption core between NUM_REQ requesters: round-robin grant,
// operand capture, START/DONE sequencing with a hung-core watchdog, result return.
module aes_job_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_job_arbiter_if.slave     bus,
  output logic                 busy,
  output logic                 aes_start,
  input  logic                 aes_done,
  output logic [127:0]         aes_key,
  output logic [127:0]         aes_msg_enc,
  input  logic [127:0]         aes_msg_dec,
  output logic [1:0]           dbg_state
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        pick_lo;
  logic [GW-1:0]        pick_hi;
  logic                 hi_found;
  logic                 any_req;
  logic                 first_run;
  logic                 timeout_hit;
  logic [31:0]          wdog;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [127:0]         sel_key;
  logic [127:0]         sel_msg;

  // Round-robin: lowest requester above last_grant wins, else wrap to the lowest requester.
  always_comb begin
    any_req  = |bus.req_valid;
    pick_lo  = '0;
    pick_hi  = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) pick_lo = GW'(i);
      if (bus.req_valid[i] && (i > int'(last_grant))) begin
        pick_hi  = GW'(i);
        hi_found = 1'b1;
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_key = '0;
    sel_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        sel_key = bus.req_key[128*i +: 128];
        sel_msg = bus.req_msg[128*i +: 128];
      end
    end
  end

  assign grant_oh    = NUM_REQ'(1) << last_grant;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      wdog         <= '0;
      first_run    <= 1'b0;
      aes_key      <= '0;
      aes_msg_enc  <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant  <= pick;
            aes_key     <= sel_key;
            aes_msg_enc <= sel_msg;
            wdog        <= '0;
            first_run   <= 1'b1;
          end
        end
        RUN: begin
          first_run <= 1'b0;
          wdog      <= wdog + 32'd1;
          // A result arriving in the timeout cycle still wins over the abort.
          if (aes_done) begin
            bus.rsp_data <= aes_msg_dec;
            bus.rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = RUN;
      RUN:     if (aes_done || timeout_hit) state_nxt = DRAIN;
      // Wait for the core to lower DONE so the next job never sees a stale result.
      DRAIN:   if (!aes_done) state_nxt = RESP;
      RESP:    if (|(bus.rsp_ready & grant_oh)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    aes_start     = (state == RUN);
    busy          = (state != IDLE);
    bus.req_ack   = (state == RUN && first_run) ? grant_oh : '0;
    bus.rsp_valid = (state == RESP) ? grant_oh : '0;
    dbg_state     = state;
  end

endmodule
